avst_frame_arbiter: RTL

- Shares one Avalon-ST video sink (the oneAPI kernel input) between two Avalon-ST pixel sources, each carrying 2 pixels/beat with 96-bit data.
- Sources mark start-of-frame with sop and end-of-line with eop.
- The block grants the sink to one source per whole frame, round-robin, and releases the grant only after LINES_PER_FRAME eop beats.
- It discards stray beats that arrive outside a frame and flags frames that restart early.

---
 rtl/avst_frame_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/avst_frame_arbiter.sv
// Whole-frame round-robin arbiter sharing one Avalon-ST video sink between two
// pixel sources; the data path is a pure combinational mux (zero latency).
module avst_frame_arbiter #(
  parameter int DATA_W          = 96,
  parameter int EMPTY_W         = 4,
  parameter int LINES_PER_FRAME = 1080,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               s0_ready,
  input  logic               s0_valid,
  input  logic [DATA_W-1:0]  s0_data,
  input  logic               s0_sop,
  input  logic               s0_eop,
  input  logic [EMPTY_W-1:0] s0_empty,
  output logic               s1_ready,
  input  logic               s1_valid,
  input  logic [DATA_W-1:0]  s1_data,
  input  logic               s1_sop,
  input  logic               s1_eop,
  input  logic [EMPTY_W-1:0] s1_empty,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_sop,
  output logic               m_eop,
  output logic [EMPTY_W-1:0] m_empty,
  output logic               grant_id,
  output logic               busy,
  output logic               frame_done,
  output logic               short_frame_err,
  output logic [CNT_W-1:0]   drop_count
);
  // Handshake: a beat moves on a rising edge where valid && ready are both 1;
  // ready may depend combinationally on valid, valid never depends on ready.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_grant_id;
  logic             r_last_grant;
  logic             r_first;
  logic             r_frame_done;
  logic             r_short_err;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_line_base;
  logic [CNT_W-1:0] w_line_nxt;
  logic [CNT_W:0]   w_drop_sum;
  logic [1:0]       w_drop_inc;
  logic             w_req0, w_req1, w_stray0, w_stray1, w_pick;
  logic             w_start, w_hs, w_close, w_restart;
  logic             w_sel_valid, w_sel_sop, w_sel_eop;

  assign w_req0   = s0_valid & s0_sop;
  assign w_req1   = s1_valid & s1_sop;
  assign w_stray0 = s0_valid & ~s0_sop;
  assign w_stray1 = s1_valid & ~s1_sop;
  assign w_pick   = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

  assign w_sel_valid = r_grant_id ? s1_valid : s0_valid;
  assign w_sel_sop   = r_grant_id ? s1_sop   : s0_sop;
  assign w_sel_eop   = r_grant_id ? s1_eop   : s0_eop;

  assign m_data  = r_grant_id ? s1_data  : s0_data;
  assign m_empty = r_grant_id ? s1_empty : s0_empty;
  assign m_sop   = w_sel_sop;
  assign m_eop   = w_sel_eop;

  assign grant_id        = r_grant_id;
  assign busy            = (r_state == GRANT);
  assign frame_done      = r_frame_done;
  assign short_frame_err = r_short_err;
  assign drop_count      = r_drop_cnt;

  always_comb begin
    w_next_state = r_state;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    m_valid      = 1'b0;
    w_start      = 1'b0;
    w_hs         = 1'b0;
    w_close      = 1'b0;
    w_restart    = 1'b0;
    w_drop_inc   = 2'd0;
    w_line_base  = r_line_cnt;
    w_line_nxt   = r_line_cnt;
    case (r_state)
      IDLE: begin
        // Stray beats are swallowed; sop requests are held until granted.
        s0_ready   = w_stray0 & resetn;
        s1_ready   = w_stray1 & resetn;
        w_drop_inc = {1'b0, w_stray0} + {1'b0, w_stray1};
        if (w_req0 | w_req1) begin
          w_next_state = GRANT;
          w_start      = 1'b1;
        end
      end
      GRANT: begin
        m_valid  = w_sel_valid;
        s0_ready = m_ready & ~r_grant_id;
        s1_ready = m_ready & r_grant_id;
        w_hs     = w_sel_valid & m_ready;
        if (w_hs) begin
          // A repeated sop restarts the line count as if the frame began here.
          w_restart   = w_sel_sop & (~r_first | (r_line_cnt != '0));
          w_line_base = w_restart ? '0 : r_line_cnt;
          w_line_nxt  = w_line_base + CNT_W'(w_sel_eop);
          if (w_sel_eop && (w_line_base == LAST_LINE)) begin
            w_close      = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_drop_inc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_first      <= 1'b0;
      r_line_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_short_err  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_frame_done <= w_close;
      r_short_err  <= w_restart;
      r_drop_cnt   <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      if (w_start) begin
        r_grant_id   <= w_pick;
        r_last_grant <= w_pick;
        r_line_cnt   <= '0;
        r_first      <= 1'b1;
      end else if (w_hs) begin
        r_first    <= 1'b0;
        r_line_cnt <= w_line_nxt;
      end
    end
  end

endmodule
